// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides, carry/zero/
// negative/overflow flags, a persistent carry for add-with-carry and a W-cycle
// shift-add multiplier.
module alu_pipe #(
    parameter int unsigned W   = 8,
    parameter int unsigned OPW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic           carry,
    output logic           zero,
    output logic           neg,
    output logic           ovf,
    output logic           cflag
);

    localparam int unsigned CW = $clog2(W);
    localparam int unsigned PW = 2 * W;

    localparam logic [OPW-1:0] OP_PASS_A    = OPW'(0);
    localparam logic [OPW-1:0] OP_SHL       = OPW'(1);
    localparam logic [OPW-1:0] OP_SHR       = OPW'(2);
    localparam logic [OPW-1:0] OP_MAX       = OPW'(3);
    localparam logic [OPW-1:0] OP_SHIFT_ON  = OPW'(4);
    localparam logic [OPW-1:0] OP_ADD       = OPW'(5);
    localparam logic [OPW-1:0] OP_A_IS_ZERO = OPW'(6);
    localparam logic [OPW-1:0] OP_PASS_B    = OPW'(7);
    localparam logic [OPW-1:0] OP_INC       = OPW'(8);
    localparam logic [OPW-1:0] OP_DEC       = OPW'(9);
    localparam logic [OPW-1:0] OP_CLEAR     = OPW'(10);
    localparam logic [OPW-1:0] OP_SUB       = OPW'(11);
    localparam logic [OPW-1:0] OP_ADDC      = OPW'(12);
    localparam logic [OPW-1:0] OP_MUL       = OPW'(13);

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  mcand;
    logic [W-1:0]   mplier;
    logic [PW-1:0]  mul_prod;
    logic           accept;
    logic           start_mul;
    logic           mul_last;

    logic [W:0]     sum;
    logic [W-1:0]   alu_res;
    logic           alu_c;
    logic           alu_o;
    logic           alu_z;
    logic           upd_cf;
    logic           reserved;

    // Single-cycle ALU: result, carry, overflow and whether the op updates cflag.
    always_comb begin
        sum      = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_o    = 1'b0;
        upd_cf   = 1'b0;
        reserved = 1'b0;
        case (op)
            OP_PASS_A: begin
                alu_res = a;
            end
            OP_SHL: begin
                alu_res = {a[W-2:0], 1'b0};
                alu_c   = a[W-1];
                upd_cf  = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, a[W-1:1]};
                alu_c   = a[0];
                upd_cf  = 1'b1;
            end
            OP_MAX: begin
                alu_c   = (a > b);
                alu_res = alu_c ? a : b;
            end
            OP_SHIFT_ON: begin
                alu_res = {a[W-2:0], b[0]};
                alu_c   = a[W-1];
                upd_cf  = 1'b1;
            end
            OP_ADD: begin
                sum     = {1'b0, a} + {1'b0, b};
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_o   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
                upd_cf  = 1'b1;
            end
            OP_A_IS_ZERO: begin
                alu_c = (a == '0);
            end
            OP_PASS_B: begin
                alu_res = b;
            end
            OP_INC: begin
                sum     = {1'b0, a} + (W+1)'(1);
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_o   = !a[W-1] && sum[W-1];
            end
            OP_DEC: begin
                sum     = {1'b0, a} - (W+1)'(1);
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_o   = a[W-1] && !sum[W-1];
            end
            OP_CLEAR: begin
                alu_res = '0;
            end
            OP_SUB: begin
                sum     = {1'b0, a} - {1'b0, b};
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_o   = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
                upd_cf  = 1'b1;
            end
            OP_ADDC: begin
                sum     = {1'b0, a} + {1'b0, b} + (W+1)'(cflag);
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_o   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
                upd_cf  = 1'b1;
            end
            OP_MUL: begin
                alu_res = '0;
            end
            default: begin
                reserved = 1'b1;
            end
        endcase
        alu_z = (alu_res == '0) && !reserved;
    end

    // Product including the current shift-add step.
    always_comb begin
        mul_prod = acc + (mplier[0] ? mcand : '0);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_mul) state_next = MUL_RUN;
            MUL_RUN: if (mul_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake and multiplier control.
    always_comb begin
        in_ready  = (state == IDLE) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        start_mul = accept && (op == OP_MUL);
        mul_last  = (state == MUL_RUN) && (cnt == CW'(W - 1));
    end

    // Multiplier datapath: one shift-add step per cycle while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start_mul) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (state == MUL_RUN) begin
            acc    <= mul_prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // Output registers, valid flag and persistent carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            cflag     <= 1'b0;
            out_valid <= 1'b0;
        end else if (mul_last) begin
            result    <= mul_prod[W-1:0];
            carry     <= |mul_prod[PW-1:W];
            zero      <= (mul_prod[W-1:0] == '0);
            neg       <= mul_prod[W-1];
            ovf       <= 1'b0;
            out_valid <= 1'b1;
        end else if (accept && !start_mul) begin
            result    <= alu_res;
            carry     <= alu_c;
            zero      <= alu_z;
            neg       <= alu_res[W-1];
            ovf       <= alu_o;
            out_valid <= 1'b1;
            if (upd_cf) cflag <= alu_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (W=8 main instance, W=16 for MAX width check).
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
        logic       o;
        logic       cf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] op;
    logic [7:0] a, b, result;
    logic       carry, zero, neg, ovf, cflag;

    logic        v16, rdy16, ov16, or16, c16, z16, n16, o16, cf16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, res16;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   model_cf    = 0;
    int   last_waits  = 0;
    bit   rnd         = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.W(8), .OPW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .cflag(cflag)
    );

    alu_pipe #(.W(16), .OPW(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(v16), .in_ready(rdy16),
        .op(op16), .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
        .result(res16), .carry(c16), .zero(z16), .neg(n16), .ovf(o16), .cflag(cf16)
    );

    function automatic int sv8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic bit out_of_range(input int s);
        return (s > 127) || (s < -128);
    endfunction

    function automatic exp_t mk(input int r, input bit c, input bit z, input bit n,
                                input bit o, input bit cf);
        exp_t e;
        e.r = 8'(r); e.c = c; e.z = z; e.n = n; e.o = o; e.cf = cf;
        return e;
    endfunction

    // Reference model: integer arithmetic straight from the opcode table.
    function automatic exp_t model(input int opc, input int x, input int y,
                                   input int cf_in, output int cf_out);
        int r = 0; int s = 0; bit c = 0; bit o = 0; bit upd = 0; bit rsv = 0;
        exp_t e;
        case (opc)
            0:  r = x;
            1:  begin r = (x * 2) % 256; c = x >= 128; upd = 1; end
            2:  begin r = x / 2; c = (x % 2) == 1; upd = 1; end
            3:  begin c = x > y; r = c ? x : y; end
            4:  begin r = (x * 2 + y % 2) % 256; c = x >= 128; upd = 1; end
            5:  begin s = x + y; r = s % 256; c = s > 255;
                      o = out_of_range(sv8(x) + sv8(y)); upd = 1; end
            6:  begin r = 0; c = x == 0; end
            7:  r = y;
            8:  begin s = x + 1; r = s % 256; c = s > 255; o = sv8(x) + 1 > 127; end
            9:  begin r = (x + 255) % 256; c = x == 0; o = sv8(x) - 1 < -128; end
            10: r = 0;
            11: begin r = (x - y + 256) % 256; c = x < y;
                      o = out_of_range(sv8(x) - sv8(y)); upd = 1; end
            12: begin s = x + y + cf_in; r = s % 256; c = s > 255;
                      o = out_of_range(sv8(x) + sv8(y) + cf_in); upd = 1; end
            13: begin s = x * y; r = s % 256; c = s >= 256; end
            default: rsv = 1;
        endcase
        cf_out = upd ? int'(c) : cf_in;
        e = mk(r, c, (r == 0) && !rsv, r >= 128, o, cf_out != 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Offer one op, wait (bounded) for acceptance, push its expected response.
    task automatic issue(input int opc, input int x, input int y, input bit lit, input exp_t le);
        exp_t e;
        int   ncf;
        int   waits = 0;
        op = 4'(opc); a = 8'(x); b = 8'(y); in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        last_waits = waits;
        if (waits >= 200) begin
            check("accept_timeout", 32'(waits), 32'(0));
            @(posedge clk); #1 in_valid = 1'b0;
            return;
        end
        e = model(opc, x, y, model_cf, ncf);
        model_cf = ncf;
        q.push_back(lit ? le : e);
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'(q.size()), 32'(0));
        @(posedge clk); #1;
    endtask

    // Monitor: pop and compare whenever a result is consumed.
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (!reset && out_valid && out_ready) begin
            g = {result, carry, zero, neg, ovf, cflag};
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got %h, required no output", g);
            end else begin
                e = q.pop_front();
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL result r/c/z/n/o/cf: got %h, required %h", g, e);
                end
            end
        end
    end

    // Random consumer back-pressure, changed just after the clock edge.
    always @(posedge clk) begin
        #1;
        if (rnd) out_ready = ($urandom % 4) != 0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int stray;
        reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; or16 = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_flags", 32'({result, carry, zero, neg, ovf, cflag}), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(1));
        check("reset16_out_valid", 32'(ov16), 32'(0));
        @(posedge clk); #1;

        // Carry chain, subtract and overflow
        issue(5,  'hFF, 'h01, 1, mk('h00, 1, 1, 0, 0, 1));
        issue(12, 'h10, 'h20, 1, mk('h31, 0, 0, 0, 0, 0));
        issue(11, 'h05, 'h07, 1, mk('hFE, 1, 0, 1, 0, 1));
        issue(5,  'h7F, 'h01, 1, mk('h80, 0, 0, 1, 1, 0));
        drain();

        // MUL latency then 3-cycle stall
        out_ready = 1'b0;
        issue(13, 'h12, 'h34, 1, mk('hA8, 1, 0, 1, 0, 0));
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mul_latency", 32'(lat), 32'(8));
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_hold", 32'({out_valid, result, carry, zero, neg, ovf, cflag}),
                  32'({1'b1, 8'hA8, 5'b10100}));
            check("stall_in_ready", 32'(in_ready), 32'(0));
        end
        drain();

        // Throughput: back-to-back PASS_B
        for (int i = 0; i < 4; i++) begin
            issue(7, $urandom_range(0, 255), $urandom_range(0, 255), 0, '0);
            check("tput_wait", 32'(last_waits), 32'(0));
            check("tput_valid", 32'(out_valid), 32'(1));
        end
        drain();

        // Boundaries
        issue(9,  'h00, 'h00, 1, mk('hFF, 1, 0, 1, 0, 0));
        issue(6,  'h00, 'h5A, 1, mk('h00, 1, 1, 0, 0, 0));
        issue(15, 'hFF, 'hFF, 1, mk('h00, 0, 0, 0, 0, 0));
        drain();

        // W=16 MAX with top-bit operand
        check("w16_in_ready", 32'(rdy16), 32'(1));
        op16 = 4'd3; a16 = 16'h8000; b16 = 16'h7FFF; v16 = 1'b1;
        @(posedge clk); #1 v16 = 1'b0;
        check("w16_max", 32'({ov16, res16, c16, z16, n16, o16, cf16}),
              32'({1'b1, 16'h8000, 5'b10100}));

        // Reset in the middle of a MUL, with cflag set beforehand
        issue(1, 'h80, 'h00, 0, '0);
        drain();
        op = 4'd13; a = 8'h0F; b = 8'h0F; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_cf = 0;
        @(negedge clk);
        check("rst_mul_out_valid", 32'(out_valid), 32'(0));
        check("rst_mul_cflag", 32'(cflag), 32'(0));
        check("rst_mul_in_ready", 32'(in_ready), 32'(1));
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("rst_mul_stray", 32'(stray), 32'(0));
        @(posedge clk); #1;

        // Randomized ops with random back-pressure
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255), 0, '0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rnd = 1'b0;
        @(posedge clk); #2;
        drain();
        check("queue_empty", 32'(q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the datapath's 8-bit combinational ALU.
- Sits between the decode/register-read stage and writeback, with a valid/ready handshake on both sides.
- Adds real carry/zero/negative/overflow flags, a persistent carry flag for add-with-carry, and a multi-cycle shift-add multiply.

Parameters:
- W, 8: operand/result width (W >= 4).
- OPW, 4: opcode width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts the operation this cycle.
- op  in  OPW  opcode (encoding below).
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result held on the outputs.
- out_ready  in  1  consumer takes the result.
- result  out  W  result value.
- carry  out  1  carry/borrow flag for this result.
- zero  out  1  set when result == 0.
- neg  out  1  set to result[W-1].
- ovf  out  1  signed overflow (ADD/ADDC/SUB/INC/DEC only, else 0).
- cflag  out  1  persistent carry register.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high. Reset forces result=0, carry=zero=neg=ovf=0, cflag=0, out_valid=0, MUL state to IDLE.
- Reset mid-MUL aborts the operation; no result is produced.
- Accept rule: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops therefore give one result per cycle.
- Single-cycle ops: latency 1. On accept, the output registers load on that edge and out_valid=1 from the next cycle.
- Output hold: while out_valid && !out_ready, all outputs are held stable.
- Opcode encoding and function. Sums are computed at W+1 bits; carry = bit W unless stated.
  - 0 PASS_A: a; carry=0.
  - 1 SHL: a<<1; carry=a[W-1].
  - 2 SHR: logical a>>1; carry=a[0].
  - 3 MAX: unsigned larger of a, b; carry=(a>b).
  - 4 SHIFT_ON: (a<<1)|b[0]; carry=a[W-1].
  - 5 ADD: a+b.
  - 6 A_IS_ZERO: result=0; carry=(a==0).
  - 7 PASS_B: b; carry=0.
  - 8 INC: a+1.
  - 9 DEC: a-1; carry=borrow (a==0).
  - 10 CLEAR: 0; carry=0.
  - 11 SUB: a-b; carry=borrow (a<b unsigned).
  - 12 ADDC: a+b+cflag.
  - 13 MUL: low W bits of a*b; carry=1 if the high W bits are nonzero.
  - 14-15: reserved; result=0, all flags 0, still completes in 1 cycle.
- ovf: ADD/ADDC/INC = operand signs equal and result sign differs. SUB/DEC = operand signs differ and result sign differs from a.
- cflag: updates to the op's carry on completion of ADD, ADDC, SUB, SHL, SHR, SHIFT_ON. Other ops leave it unchanged.
- MUL FSM, states IDLE -> MUL_RUN -> IDLE:
  - On accept, latch a, b and clear a 2W-bit accumulator.
  - One shift-add step per cycle for exactly W cycles; a counter runs 0..W-1. in_ready=0 throughout.
  - On the last step, load outputs and set out_valid. Total latency = W cycles (8 at default).
  - The FSM returns to IDLE on the same edge.
  - If the previous result is still stalled, MUL is not accepted, because in_ready=0.
- Simultaneous consume and accept: with out_valid && out_ready && in_valid, the new single-cycle result replaces the old one in the same edge and out_valid stays 1.
- Widths: all arithmetic is modulo 2^W. No X propagation; outputs are fully defined for every opcode.

Test Plan:
- Reset: assert reset 2 cycles mid-MUL (W=8) -> out_valid=0, cflag=0, in_ready=1 the cycle after reset drops, no stray result.
- ADD then ADDC carry chain: ADD a=0xFF b=0x01 -> result 0x00, carry=1, zero=1, cflag=1. Next ADDC a=0x10 b=0x20 -> result 0x31, cflag=0.
- SUB and overflow: SUB a=0x05 b=0x07 -> 0xFE, carry=1, neg=1. ADD a=0x7F b=0x01 -> 0x80, ovf=1.
- MUL latency and stall: MUL a=0x12 b=0x34 -> result 0xA8, carry=1, out_valid exactly 8 cycles after accept. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
- Throughput: 4 back-to-back PASS_B with out_ready=1 -> 4 results on consecutive cycles, in_ready never deasserts.
- Boundaries: DEC a=0x00 -> 0xFF, carry=1. A_IS_ZERO a=0 -> carry=1, zero=1. Op 15 -> result 0, flags 0. At W=16, MAX a=0x8000 b=0x7FFF -> 0x8000.
